// File: rtl/asat_pipe_adder_tree_pkg.sv
// Shared helpers for the ASAT adder tree: level sizing, signed clamp and overflow mode.
package asat_pkg;

    typedef enum logic {WRAP = 1'b0, SAT = 1'b1} asat_ovf_mode_e;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Number of elements present at tree level k (level 0 = the raw operands).
    function automatic int level_count(input int n, input int k);
        return (n + (1 << k) - 1) >> k;
    endfunction

    function automatic int lvl_off(input int n, input int k, input int w);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) s += level_count(n, j) * w;
        return s;
    endfunction

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/asat_pipe_adder_tree_if.sv
// Operand-vector in / result out handshake bundle for the ASAT adder tree.
interface asat_pipe_adder_tree_if #(
    parameter int DATA_W = 32,
    parameter int NUM_IN = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/asat_pipe_adder_tree_add_level.sv
// One registered tree level: adds adjacent pairs, passes an odd last element through.
// The final level also converts to DATA_W (wrap or clamp) and stores the overflow bit as MSB.
module asat_add_level
    import asat_pkg::*;
#(
    parameter int W        = 34,
    parameter int NUM_EL   = 3,
    parameter int FINAL    = 0,
    parameter int DATA_W   = 32,
    parameter int SATURATE = 0,
    localparam int NUM_OUT = (NUM_EL + 1) / 2,
    localparam int OW      = (FINAL != 0) ? DATA_W + 1 : W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  in_vld,
    input  logic [NUM_EL*W-1:0]   in_dat,
    output logic                  out_vld,
    output logic [NUM_OUT*OW-1:0] out_dat
);
    localparam asat_ovf_mode_e MODE = (SATURATE != 0) ? SAT : WRAP;

    logic [NUM_OUT*W-1:0]  sum_c;
    logic [NUM_OUT*OW-1:0] nxt;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_pair
        if (2*i + 1 < NUM_EL) begin : g_add
            assign sum_c[i*W +: W] = in_dat[2*i*W +: W] + in_dat[(2*i+1)*W +: W];
        end else begin : g_pass
            assign sum_c[i*W +: W] = in_dat[2*i*W +: W];
        end
    end

    if (FINAL != 0) begin : g_conv
        logic signed [63:0] full;
        logic [DATA_W-1:0]  res;
        assign full = 64'(signed'(sum_c));
        assign res  = (MODE == SAT) ? DATA_W'(sat_signed(full, DATA_W)) : DATA_W'(full);
        assign nxt  = {sat_signed(full, DATA_W) != full, res};
    end else begin : g_mid
        assign nxt = sum_c;
    end

    // Data only loads on a valid beat so bubbles never disturb held values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (!hold) begin
            out_vld <= in_vld;
            if (in_vld) out_dat <= nxt;
        end
    end
endmodule

// File: rtl/asat_pipe_adder_tree.sv
// Sums NUM_IN signed operands in a registered binary tree: LVL-cycle latency, one result per cycle.
// All stages hold and in_ready drops while out_valid & ~out_ready; ASAT_ADDER_DEBUG_EN adds level-1 taps.
module asat_pipe_adder_tree
    import asat_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_IN   = 3,
    parameter int SATURATE = 0,
    localparam int LVL     = clog2_min1(NUM_IN),
    localparam int INT_W   = DATA_W + LVL
) (
    input  logic clk,
    input  logic rst,
    asat_pipe_adder_tree_if.slave bus
`ifdef ASAT_ADDER_DEBUG_EN
    ,
    output logic [INT_W-1:0] dbg_sum_stage1,
    output logic [INT_W-1:0] dbg_pass_stage1
`endif
);
    localparam int TREE_W = lvl_off(NUM_IN, LVL, INT_W);

    logic              stall;
    logic              accept;
    logic [LVL:0]      vld;
    logic [TREE_W-1:0] tree;
    logic [DATA_W:0]   res;

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall & rst;
    assign accept       = bus.in_valid & bus.in_ready;
    assign vld[0]       = accept;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_op
        assign tree[i*INT_W +: INT_W] = INT_W'(signed'(bus.in_data[i*DATA_W +: DATA_W]));
    end

    // Each level's elements occupy a contiguous slice of tree; the last level feeds res.
    for (genvar k = 1; k <= LVL; k++) begin : g_lvl
        localparam int NE = level_count(NUM_IN, k - 1);
        localparam int NO = level_count(NUM_IN, k);
        localparam int FN = (k == LVL) ? 1 : 0;
        localparam int OW = (FN != 0) ? DATA_W + 1 : INT_W;

        logic [NO*OW-1:0] q;

        asat_add_level #(
            .W        (INT_W),
            .NUM_EL   (NE),
            .FINAL    (FN),
            .DATA_W   (DATA_W),
            .SATURATE (SATURATE)
        ) u_level (
            .clk     (clk),
            .rst     (rst),
            .hold    (stall),
            .in_vld  (vld[k-1]),
            .in_dat  (tree[lvl_off(NUM_IN, k - 1, INT_W) +: NE*INT_W]),
            .out_vld (vld[k]),
            .out_dat (q)
        );

        if (FN != 0) begin : g_out
            assign res = q;
        end else begin : g_next
            assign tree[lvl_off(NUM_IN, k, INT_W) +: NO*INT_W] = q;
        end
    end

    assign bus.out_valid = vld[LVL];
    assign bus.out_data  = res[DATA_W-1:0];
    assign bus.out_ovf   = res[DATA_W];

`ifdef ASAT_ADDER_DEBUG_EN
    localparam int HI = ((NUM_IN % 2) != 0) ? NUM_IN - 1 : NUM_IN - 2;

    logic [INT_W-1:0] pass_c;

    if ((NUM_IN % 2) != 0) begin : g_dbg_odd
        assign pass_c = tree[HI*INT_W +: INT_W];
    end else begin : g_dbg_even
        assign pass_c = tree[HI*INT_W +: INT_W] + tree[(HI+1)*INT_W +: INT_W];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dbg_sum_stage1  <= '0;
            dbg_pass_stage1 <= '0;
        end else if (!stall && accept) begin
            dbg_sum_stage1  <= tree[0 +: INT_W] + tree[INT_W +: INT_W];
            dbg_pass_stage1 <= pass_c;
        end
    end
`endif
endmodule

// File: tb/tb_asat_pipe_adder_tree.sv
// Scoreboard bench: default 32x3 wrap, 8x4 saturate and 8x4 wrap instances against an arithmetic model.
module tb_asat_pipe_adder_tree;

    typedef struct {
        longint d;
        bit     o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   last_hs_a = -1;
    bit   tog_done;

    exp_t q_a[$];
    exp_t q_s[$];
    exp_t q_w[$];
    exp_t e_a, e_s, e_w;

    asat_pipe_adder_tree_if #(.DATA_W(32), .NUM_IN(3)) bus_a();
    asat_pipe_adder_tree_if #(.DATA_W(8),  .NUM_IN(4)) bus_s();
    asat_pipe_adder_tree_if #(.DATA_W(8),  .NUM_IN(4)) bus_w();

`ifdef ASAT_ADDER_DEBUG_EN
    logic [33:0] dbg_a_sum, dbg_a_pass;
    logic [9:0]  dbg_s_sum, dbg_s_pass, dbg_w_sum, dbg_w_pass;
`endif

    asat_pipe_adder_tree #(.DATA_W(32), .NUM_IN(3), .SATURATE(0)) u_def (
        .clk(clk), .rst(rst), .bus(bus_a)
`ifdef ASAT_ADDER_DEBUG_EN
        , .dbg_sum_stage1(dbg_a_sum), .dbg_pass_stage1(dbg_a_pass)
`endif
    );

    asat_pipe_adder_tree #(.DATA_W(8), .NUM_IN(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .bus(bus_s)
`ifdef ASAT_ADDER_DEBUG_EN
        , .dbg_sum_stage1(dbg_s_sum), .dbg_pass_stage1(dbg_s_pass)
`endif
    );

    asat_pipe_adder_tree #(.DATA_W(8), .NUM_IN(4), .SATURATE(0)) u_wrp (
        .clk(clk), .rst(rst), .bus(bus_w)
`ifdef ASAT_ADDER_DEBUG_EN
        , .dbg_sum_stage1(dbg_w_sum), .dbg_pass_stage1(dbg_w_pass)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, checks so far %0d, required completion", n_chk);
        $fatal(1);
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: exact integer sum, then range test, modular wrap or clamp.
    function automatic exp_t model(input longint s, input int dw, input bit sat);
        longint hi, lo, m, r;
        exp_t   e;
        hi  = (longint'(1) << (dw - 1)) - 1;
        lo  = -hi - 1;
        m   = longint'(1) << dw;
        e.o = (s > hi) || (s < lo);
        r   = s % m;
        if (r < 0)  r += m;
        if (r > hi) r -= m;
        if (!sat)         e.d = r;
        else if (s > hi)  e.d = hi;
        else if (s < lo)  e.d = lo;
        else              e.d = s;
        return e;
    endfunction

    task automatic beat(input string tag, input bit have, input exp_t e, input longint d, input bit o);
        if (!have) chk(1'b0, {tag, "_unexpected_beat"}, d, 0);
        else begin
            chk(d == e.d, {tag, "_data"}, d, e.d);
            chk(o == e.o, {tag, "_ovf"}, o, e.o);
        end
    endtask

    bit stl_a, stl_s, stl_w;
    logic [31:0] prev_a;
    logic [7:0]  prev_s, prev_w;

    always @(negedge clk) begin
        if (!rst) stl_a = 1'b0;
        else begin
            if (stl_a) begin
                chk(bus_a.out_valid == 1'b1, "a_stall_valid_hold", bus_a.out_valid, 1);
                chk(bus_a.out_data == prev_a, "a_stall_data_hold", bus_a.out_data, prev_a);
            end
            if (bus_a.out_valid && !bus_a.out_ready)
                chk(bus_a.in_ready == 1'b0, "a_stall_in_ready", bus_a.in_ready, 0);
            if (bus_a.out_valid && bus_a.out_ready) begin
                if (q_a.size() != 0) e_a = q_a.pop_front();
                beat("a", q_a.size() >= 0 && e_a.o !== 1'bx, e_a, $signed(bus_a.out_data), bus_a.out_ovf);
                last_hs_a = cyc;
            end
            stl_a  = bus_a.out_valid && !bus_a.out_ready;
            prev_a = bus_a.out_data;
        end
    end

    always @(negedge clk) begin
        bit have;
        if (!rst) stl_s = 1'b0;
        else begin
            if (stl_s) chk(bus_s.out_data == prev_s, "s_stall_data_hold", bus_s.out_data, prev_s);
            if (bus_s.out_valid && bus_s.out_ready) begin
                have = q_s.size() != 0;
                if (have) e_s = q_s.pop_front();
                beat("s", have, e_s, $signed(bus_s.out_data), bus_s.out_ovf);
            end
            stl_s  = bus_s.out_valid && !bus_s.out_ready;
            prev_s = bus_s.out_data;
        end
    end

    always @(negedge clk) begin
        bit have;
        if (!rst) stl_w = 1'b0;
        else begin
            if (stl_w) chk(bus_w.out_data == prev_w, "w_stall_data_hold", bus_w.out_data, prev_w);
            if (bus_w.out_valid && bus_w.out_ready) begin
                have = q_w.size() != 0;
                if (have) e_w = q_w.pop_front();
                beat("w", have, e_w, $signed(bus_w.out_data), bus_w.out_ovf);
            end
            stl_w  = bus_w.out_valid && !bus_w.out_ready;
            prev_w = bus_w.out_data;
        end
    end

    // Leaves in_valid high so consecutive calls stream back to back.
    task automatic send_a(input longint a, input longint b, input longint c, output int acc);
        bit ok;
        ok  = 1'b0;
        acc = -1;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = {32'(c), 32'(b), 32'(a)};
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus_a.in_ready) begin
                ok  = 1'b1;
                acc = cyc;
                q_a.push_back(model(a + b + c, 32, 1'b0));
            end
        end
        chk(ok, "a_accept_timeout", ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic send8(input bit sat, input longint o0, input longint o1, input longint o2, input longint o3);
        bit ok;
        ok = 1'b0;
        if (sat) begin bus_s.in_valid = 1'b1; bus_s.in_data = {8'(o3), 8'(o2), 8'(o1), 8'(o0)}; end
        else     begin bus_w.in_valid = 1'b1; bus_w.in_data = {8'(o3), 8'(o2), 8'(o1), 8'(o0)}; end
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (sat ? bus_s.in_ready : bus_w.in_ready) begin
                ok = 1'b1;
                if (sat) q_s.push_back(model(o0 + o1 + o2 + o3, 8, 1'b1));
                else     q_w.push_back(model(o0 + o1 + o2 + o3, 8, 1'b0));
            end
        end
        chk(ok, sat ? "s_accept_timeout" : "w_accept_timeout", ok, 1);
        @(posedge clk); #1;
        bus_s.in_valid = 1'b0;
        bus_w.in_valid = 1'b0;
    endtask

    task automatic drain(input int which);
        int n;
        for (int i = 0; i < 300; i++) begin
            n = (which == 0) ? q_a.size() : (which == 1) ? q_s.size() : q_w.size();
            if (n == 0) break;
            @(negedge clk);
        end
        n = (which == 0) ? q_a.size() : (which == 1) ? q_s.size() : q_w.size();
        chk(n == 0, "drain_left", n, 0);
        @(posedge clk); #1;
    endtask

    function automatic longint r8();
        return longint'($urandom_range(255)) - 128;
    endfunction

    initial begin
        int t0, t;
        rst = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b1;
        bus_s.in_valid = 1'b0; bus_s.in_data = '0; bus_s.out_ready = 1'b1;
        bus_w.in_valid = 1'b0; bus_w.in_data = '0; bus_w.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk(bus_a.out_valid == 1'b0, "rst_out_valid", bus_a.out_valid, 0);
        chk(bus_a.out_data == '0, "rst_out_data", bus_a.out_data, 0);
        chk(bus_a.out_ovf == 1'b0, "rst_out_ovf", bus_a.out_ovf, 0);
        chk(bus_a.in_ready == 1'b0, "rst_in_ready", bus_a.in_ready, 0);
        chk(bus_s.out_valid == 1'b0, "rst_s_out_valid", bus_s.out_valid, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk(bus_a.in_ready == 1'b1, "in_ready_after_rst", bus_a.in_ready, 1);

        // Single beat: 5 + -3 + 10, two-cycle latency.
        send_a(5, -3, 10, t);
        bus_a.in_valid = 1'b0;
        chk(bus_a.out_valid == 1'b0, "a_latency_early", bus_a.out_valid, 0);
        @(posedge clk); #1;
        chk(bus_a.out_valid == 1'b1, "a_latency_2cyc", bus_a.out_valid, 1);
        drain(0);

        // Ten back-to-back beats with out_ready high.
        t0 = -1;
        for (int i = 0; i < 10; i++) begin
            send_a(longint'($urandom_range(200)) - 100, longint'($urandom_range(200)) - 100,
                   longint'($urandom_range(200)) - 100, t);
            if (i == 0) t0 = t;
        end
        bus_a.in_valid = 1'b0;
        drain(0);
        chk(last_hs_a == t0 + 11, "a_b2b_gapless", last_hs_a, t0 + 11);

        // Full-range operands exercise 32-bit wrap and overflow.
        for (int i = 0; i < 6; i++)
            send_a(longint'($signed($urandom())), longint'($signed($urandom())),
                   longint'($signed($urandom())), t);
        bus_a.in_valid = 1'b0;
        drain(0);

        // Backpressure: hold out_ready low four cycles with a third beat waiting.
        bus_a.out_ready = 1'b0;
        send_a(longint'($urandom_range(200)) - 100, 7, -8, t);
        send_a(longint'($urandom_range(200)) - 100, 9, 11, t);
        fork
            send_a(-50, 60, longint'($urandom_range(200)) - 100, t);
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk(bus_a.in_ready == 1'b0, "a_bp_in_ready", bus_a.in_ready, 0);
                    chk(bus_a.out_valid == 1'b1, "a_bp_out_valid", bus_a.out_valid, 1);
                end
                @(posedge clk); #1;
                bus_a.out_ready = 1'b1;
            end
        join
        bus_a.in_valid = 1'b0;
        drain(0);

        // Directed saturate / wrap corners.
        send8(1'b1, 100, 100, 100, -10);
        send8(1'b1, -128, -128, -128, -128);
        send8(1'b0, 100, 100, 0, 0);
        send8(1'b1, 20, -30, 40, -50);
        drain(1);
        drain(2);

        // Random operands with random consumer backpressure.
        tog_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) send8(i[0], r8(), r8(), r8(), r8());
                tog_done = 1'b1;
            end
            begin
                for (int i = 0; i < 3000 && !tog_done; i++) begin
                    @(posedge clk); #1;
                    bus_s.out_ready = 1'($urandom_range(1));
                    bus_w.out_ready = 1'($urandom_range(1));
                end
            end
        join
        bus_s.out_ready = 1'b1;
        bus_w.out_ready = 1'b1;
        drain(1);
        drain(2);

        // Reset while stalled with two beats in flight.
        bus_a.out_ready = 1'b0;
        send_a(1, 2, 3, t);
        send_a(4, 5, 6, t);
        bus_a.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk(bus_a.out_valid == 1'b0, "a_rst_stall_out_valid", bus_a.out_valid, 0);
        chk(bus_a.out_data == '0, "a_rst_stall_out_data", bus_a.out_data, 0);
        chk(bus_a.out_ovf == 1'b0, "a_rst_stall_out_ovf", bus_a.out_ovf, 0);
        chk(bus_a.in_ready == 1'b0, "a_rst_stall_in_ready", bus_a.in_ready, 0);
        q_a.delete();
        rst = 1'b1;
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        chk(bus_a.in_ready == 1'b1, "a_ready_after_rst", bus_a.in_ready, 1);
        chk(bus_a.out_valid == 1'b0, "a_no_stale_after_rst", bus_a.out_valid, 0);
        send_a(-1000, 250, 17, t);
        bus_a.in_valid = 1'b0;
        drain(0);
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/asat_pipe_adder_tree.md
Name: asat_pipe_adder_tree

Overview:
- Parametrised successor to the 3-operand two-stage signed pipeline adder.
- Sums NUM_IN signed DATA_W operands through a registered binary adder tree.
- Adds valid/ready flow control with backpressure, selectable wrap or saturate output, and an overflow flag.
- Sits in the ASAT datapath between operand producers and the accumulate/compare stage.

Parameters:
- DATA_W, 32: width of each signed operand and of the result.
- NUM_IN, 3: operand count, legal range 2..16.
- SATURATE, 0: 0 = result wraps to DATA_W (two's complement); 1 = result clamps to DATA_W signed min/max.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-low reset (0 = reset).
- in_valid  in  1  operand vector valid.
- in_ready  out  1  block can accept this cycle.
- in_data  in  NUM_IN*DATA_W  packed signed operands; operand i at [i*DATA_W +: DATA_W].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  signed sum after wrap/saturate.
- out_ovf  out  1  full-precision sum outside DATA_W signed range; aligned with out_data.

Behaviour:
- Derived widths:
  - LVL = clog2(NUM_IN), minimum 1.
  - INT_W = DATA_W + LVL; internal arithmetic is full precision and sign-extended.
- Tree structure:
  - Operands are zero-padded up to 2^LVL.
  - Level k adds adjacent pairs from level k-1 and registers them.
  - An unpaired element passes through the register unchanged.
- Latency: exactly LVL cycles from accept (in_valid & in_ready) to out_valid when not stalled. Default NUM_IN=3 gives LVL=2.
- Per-level valid bit travels with the data; a bubble produces no output.
- Stall rule:
  - stall = out_valid & ~out_ready.
  - While stalled, every pipeline register holds and in_ready = 0.
  - in_ready = ~stall & rst (forced 0 during reset).
  - This is combinational from out_valid/out_ready; no combinational path from in_valid.
- Throughput: one result per cycle with out_ready held high.
- Output conversion, applied to the full sum before the final register:
  - SATURATE=0: out_data = low DATA_W bits.
  - SATURATE=1: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_ovf = 1 whenever the full sum is outside that range, in either mode.
- Handshake rules:
  - out_data and out_ovf hold stable while out_valid & ~out_ready.
  - in_data is sampled only on accept.
- Reset (rst=0 at clk edge): all valid bits, data registers, out_data and out_ovf go to 0, and in-flight data is discarded, including reset mid-stall. First accept is possible on the cycle after rst returns to 1.
- Simultaneous out handshake and new accept in the same cycle: the pipe advances normally with no lost or duplicated beat.

Optional Feature:
- Macro: ASAT_ADDER_DEBUG_EN.
- When defined, two extra outputs are added:
  - dbg_sum_stage1 (INT_W): level-1 pair-0 register, i.e. operand0 + operand1.
  - dbg_pass_stage1 (INT_W): level-1 register of the highest-index element (unpaired pass-through or last pair).
  - Both are reset to 0 and stall together with the pipe.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package asat_pkg holds:
  - function clog2_min1;
  - function sat_signed(value, width);
  - typedef enum {WRAP, SAT} asat_ovf_mode_e, mapped from SATURATE.
- Sub-module asat_add_level holds one tree level: NUM_EL inputs, ceil(NUM_EL/2) registered outputs, valid bit and hold enable. The top instantiates it LVL times in a generate loop.

Test Plan:
- Default params, out_ready=1; accept A=5, B=-3, C=10 → out_valid exactly 2 cycles later with out_data=12, out_ovf=0.
- Default params; 10 back-to-back random vectors in [-100,100] with out_ready=1 → 10 consecutive results matching the model, no gaps, in order.
- Default params; hold out_ready=0 for 4 cycles while a result is valid → in_ready=0 throughout, out_data stable. Release → remaining beats drain in order with none lost.
- DATA_W=8, NUM_IN=4, SATURATE=1; operands 100,100,100,-10 → out_data=127, out_ovf=1. Operands -128 x4 → out_data=-128, out_ovf=1.
- DATA_W=8, NUM_IN=4, SATURATE=0; operands 100,100,0,0 → out_data=-56, out_ovf=1.
- Default params; assert rst=0 for one cycle with 2 beats in flight and out_ready=0 → next cycle out_valid=0, out_data=0, out_ovf=0, in_ready=0. One cycle after rst=1 → in_ready=1.
